// File: rtl/fpu_result_uart_tx.sv
// 8N1 UART transmitter for 16-bit FPU results: FIFO-buffered, low byte first, runtime bit period.
// Optional FPU_UART_TX_HEADER_EN prefixes each result with a 0xA5 header byte (3 bytes per result).
module fpu_result_uart_tx #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [15:0]                 clks_per_bit,
  input  logic                        wr_en,
  input  logic [15:0]                 result_data,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        overflow,
  output logic                        o_tx_serial,
  output logic                        o_tx_active,
  output logic                        o_tx_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

`ifdef FPU_UART_TX_HEADER_EN
  localparam logic [1:0] LAST_BYTE = 2'd2;
  localparam logic [7:0] HEADER    = 8'hA5;
`else
  localparam logic [1:0] LAST_BYTE = 2'd1;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t      r_state;
  logic [15:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          r_overflow;
  logic [15:0]   r_hold;
  logic [15:0]   r_period;
  logic [15:0]   r_cnt;
  logic [2:0]    r_bit;
  logic [1:0]    r_byte;
  logic          r_serial;
  logic          r_active;
  logic          r_done;

  logic       w_full;
  logic       w_empty;
  logic       w_push;
  logic       w_pop;
  logic       w_bit_end;
  logic [7:0] w_cur_byte;

  assign w_full    = (r_level == LW'(FIFO_DEPTH));
  assign w_empty   = (r_level == '0);
  // full is taken before any same-cycle pop, so a push into a full FIFO always drops
  assign w_push    = wr_en & ~w_full;
  assign w_pop     = (r_state == IDLE) & ~w_empty;
  assign w_bit_end = (r_cnt == (r_period - 16'd1));

  assign full        = w_full;
  assign empty       = w_empty;
  assign level       = r_level;
  assign overflow    = r_overflow;
  assign o_tx_serial = r_serial;
  assign o_tx_active = r_active;
  assign o_tx_done   = r_done;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= result_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (wr_en && w_full) begin
        r_overflow <= 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_comb begin
    w_cur_byte = r_hold[7:0];
`ifdef FPU_UART_TX_HEADER_EN
    case (r_byte)
      2'd0:    w_cur_byte = HEADER;
      2'd1:    w_cur_byte = r_hold[7:0];
      default: w_cur_byte = r_hold[15:8];
    endcase
`else
    if (r_byte != 2'd0) begin
      w_cur_byte = r_hold[15:8];
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_hold   <= '0;
      r_period <= 16'd1;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_byte   <= '0;
      r_serial <= 1'b1;
      r_active <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_hold   <= r_mem[r_rd_ptr];
            r_period <= (clks_per_bit == 16'd0) ? 16'd1 : clks_per_bit;
            r_byte   <= '0;
            r_cnt    <= '0;
            r_serial <= 1'b0;
            r_active <= 1'b1;
            r_state  <= START;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_cnt    <= '0;
            r_bit    <= '0;
            r_serial <= w_cur_byte[0];
            r_state  <= DATA;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_bit == 3'd7) begin
              r_serial <= 1'b1;
              r_state  <= STOP;
            end else begin
              r_bit    <= r_bit + 3'd1;
              r_serial <= w_cur_byte[r_bit + 3'd1];
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        STOP: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_byte == LAST_BYTE) begin
              r_active <= 1'b0;
              r_done   <= 1'b1;
              r_state  <= IDLE;
            end else begin
              // next byte starts straight after this stop bit, no idle gap
              r_byte   <= r_byte + 2'd1;
              r_serial <= 1'b0;
              r_state  <= START;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_result_uart_tx.sv
// Directed bench for fpu_result_uart_tx: decodes the UART line cycle by cycle and checks framing and timing.
module tb_fpu_result_uart_tx;

`ifdef FPU_UART_TX_HEADER_EN
  localparam int NB = 3;
`else
  localparam int NB = 2;
`endif

  logic        clk;
  logic        rst;
  logic [15:0] clks_per_bit;
  logic        wr_en;
  logic [15:0] result_data;
  logic        full;
  logic        empty;
  logic [2:0]  level;
  logic        overflow;
  logic        o_tx_serial;
  logic        o_tx_active;
  logic        o_tx_done;

  int checks = 0;
  int errors = 0;

  fpu_result_uart_tx #(.FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .clks_per_bit (clks_per_bit),
    .wr_en        (wr_en),
    .result_data  (result_data),
    .full         (full),
    .empty        (empty),
    .level        (level),
    .overflow     (overflow),
    .o_tx_serial  (o_tx_serial),
    .o_tx_active  (o_tx_active),
    .o_tx_done    (o_tx_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [23:0] expect_frame(input logic [15:0] w);
`ifdef FPU_UART_TX_HEADER_EN
    return {w, 8'hA5};
`else
    return {8'h00, w};
`endif
  endfunction

  // Called at a negedge; drives one push and returns at the negedge after the push edge.
  task automatic push_word(input logic [15:0] v);
    wr_en = 1'b1;
    result_data = v;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Waits for a start bit, then demands exact bit-period framing for NB bytes and a done pulse right after.
  task automatic rx_result(input int per, output logic [23:0] data, output bit ok, output bit done_ok);
    int t;
    logic b;
    data = '0;
    ok = 1'b1;
    done_ok = 1'b0;
    b = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (o_tx_serial !== 1'b0 && t < 4000);
    if (o_tx_serial !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    for (int by = 0; by < NB; by++) begin
      for (int s = 0; s < 10; s++) begin
        for (int c = 0; c < per; c++) begin
          if (!(by == 0 && s == 0 && c == 0)) @(negedge clk);
          if (c == 0) b = o_tx_serial;
          if (o_tx_serial !== b) ok = 1'b0;
          if (o_tx_active !== 1'b1 || o_tx_done !== 1'b0) ok = 1'b0;
          if (s == 0 && b !== 1'b0) ok = 1'b0;
          if (s == 9 && b !== 1'b1) ok = 1'b0;
          if (s >= 1 && s <= 8 && c == 0) data[by*8 + s - 1] = b;
        end
      end
    end
    @(negedge clk);
    done_ok = (o_tx_done === 1'b1 && o_tx_serial === 1'b1 && o_tx_active === 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wr_en = 1'b0;
    result_data = '0;
    clks_per_bit = 16'd4;
    repeat (3) @(negedge clk);
    checks++; if (o_tx_serial !== 1'b1) begin errors++; $display("FAIL reset_serial got %b want 1", o_tx_serial); end
    checks++; if (o_tx_active !== 1'b0) begin errors++; $display("FAIL reset_active got %b want 0", o_tx_active); end
    checks++; if (o_tx_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", o_tx_done); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", empty); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [23:0] d;
    bit ok, dn;
    clks_per_bit = 16'd4;
    push_word(16'h3F80);
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL basic_empty_after_push got %b want 0", empty); end
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL basic_level_after_push got %0d want 1", level); end
    rx_result(4, d, ok, dn);
    checks++; if (d !== expect_frame(16'h3F80)) begin errors++; $display("FAIL basic_data got %h want %h", d, expect_frame(16'h3F80)); end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL basic_framing got %b want 1", ok); end
    checks++; if (dn !== 1'b1) begin errors++; $display("FAIL basic_done_timing got %b want 1", dn); end
    @(negedge clk);
    checks++; if (o_tx_done !== 1'b0) begin errors++; $display("FAIL basic_done_one_cycle got %b want 0", o_tx_done); end
  endtask

  task automatic test_fifo_overflow();
    bit quiet;
    clks_per_bit = 16'd2;
    fork
      begin
        for (int v = 1; v <= 5; v++) begin
          wr_en = 1'b1;
          result_data = 16'(v);
          @(negedge clk);
        end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_after5_overflow got %b want 0", overflow); end
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL ovf_after5_level got %0d want 4", level); end
        result_data = 16'h0006;
        @(negedge clk);
        result_data = 16'h0007;
        @(negedge clk);
        wr_en = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_after7_overflow got %b want 1", overflow); end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_after7_full got %b want 1", full); end
      end
      begin
        for (int k = 0; k < 5; k++) begin
          logic [23:0] d;
          bit ok, dn;
          rx_result(2, d, ok, dn);
          checks++; if (d !== expect_frame(16'(k + 1))) begin errors++; $display("FAIL ovf_word%0d got %h want %h", k, d, expect_frame(16'(k + 1))); end
          checks++; if (!(ok && dn)) begin errors++; $display("FAIL ovf_word%0d_framing got %b%b want 11", k, ok, dn); end
        end
      end
    join
    quiet = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (o_tx_serial !== 1'b1 || o_tx_active !== 1'b0) quiet = 1'b0;
    end
    checks++; if (quiet !== 1'b1) begin errors++; $display("FAIL ovf_no_sixth_word got %b want 1", quiet); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ovf_final_empty got %b want 1", empty); end
  endtask

  task automatic test_period_change();
    logic [23:0] d;
    bit ok, dn;
    clks_per_bit = 16'd8;
    push_word(16'h1234);
    fork
      rx_result(8, d, ok, dn);
      begin
        repeat (30) @(negedge clk);
        clks_per_bit = 16'd2;
      end
    join
    checks++; if (d !== expect_frame(16'h1234)) begin errors++; $display("FAIL per8_data got %h want %h", d, expect_frame(16'h1234)); end
    checks++; if (!(ok && dn)) begin errors++; $display("FAIL per8_framing got %b%b want 11", ok, dn); end
    push_word(16'hABCD);
    rx_result(2, d, ok, dn);
    checks++; if (d !== expect_frame(16'hABCD)) begin errors++; $display("FAIL per2_data got %h want %h", d, expect_frame(16'hABCD)); end
    checks++; if (!(ok && dn)) begin errors++; $display("FAIL per2_framing got %b%b want 11", ok, dn); end
  endtask

  task automatic test_reset_midframe();
    bit quiet;
    clks_per_bit = 16'd2;
    push_word(16'h5A5A);
    push_word(16'h1111);
    repeat (26) @(negedge clk);
    checks++; if (o_tx_active !== 1'b1) begin errors++; $display("FAIL midrst_active_before got %b want 1", o_tx_active); end
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL midrst_level_before got %0d want 1", level); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (o_tx_serial !== 1'b1) begin errors++; $display("FAIL midrst_serial got %b want 1", o_tx_serial); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL midrst_empty got %b want 1", empty); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL midrst_level got %0d want 0", level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL midrst_overflow got %b want 0", overflow); end
    checks++; if (o_tx_active !== 1'b0) begin errors++; $display("FAIL midrst_active got %b want 0", o_tx_active); end
    quiet = 1'b1;
    repeat (80) begin
      @(negedge clk);
      if (o_tx_done !== 1'b0 || o_tx_serial !== 1'b1) quiet = 1'b0;
    end
    checks++; if (quiet !== 1'b1) begin errors++; $display("FAIL midrst_line_quiet got %b want 1", quiet); end
  endtask

  task automatic test_zero_period();
    logic [23:0] d;
    bit ok, dn;
    clks_per_bit = 16'd0;
    push_word(16'h00FF);
    rx_result(1, d, ok, dn);
    checks++; if (d !== expect_frame(16'h00FF)) begin errors++; $display("FAIL zero_data got %h want %h", d, expect_frame(16'h00FF)); end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL zero_framing got %b want 1", ok); end
    checks++; if (dn !== 1'b1) begin errors++; $display("FAIL zero_done got %b want 1", dn); end
  endtask

`ifdef FPU_UART_TX_HEADER_EN
  task automatic test_header();
    logic [23:0] d;
    bit ok, dn;
    clks_per_bit = 16'd4;
    push_word(16'h3C00);
    rx_result(4, d, ok, dn);
    checks++; if (d !== 24'h3C00A5) begin errors++; $display("FAIL header_data got %h want 3c00a5", d); end
    checks++; if (!(ok && dn)) begin errors++; $display("FAIL header_framing got %b%b want 11", ok, dn); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_fifo_overflow();
    test_period_change();
    test_reset_midframe();
    test_zero_period();
`ifdef FPU_UART_TX_HEADER_EN
    test_header();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
